// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory ready handshake with timeout, SYSCALL halt, debug counters.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   op, func             IR[31:26], IR[5:0]
//   mem_ready            memory completes access this cycle
//   resume               pulse, leaves HALT
//   ir_write, pc_write   register enables
//   iord                 memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write  memory strobes; mem_mode 01 half, 10 word
//   alu_src_a/b          ALU operand selects
//   signed_ext           immediate sign/zero extend
//   alu_op, shift_var    ALU operation, variable shift select
//   branch, pc_src       branch kind, PC source
//   reg_write, reg_dst   register file write enable, destination
//   mem_to_reg           write-back source
//   halted, bus_err      status flags
//   illegal              one-cycle pulse on undecodable instruction
//   state                current state encoding
//   cycle_cnt, instr_cnt debug counters
module multicycle_ctrl #(
   parameter int ALU_OP_W    = 4,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          op,
   input  logic [5:0]          func,
   input  logic                mem_ready,
   input  logic                resume,
   output logic                ir_write,
   output logic                pc_write,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic [1:0]          mem_mode,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                signed_ext,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                shift_var,
   output logic [1:0]          branch,
   output logic [1:0]          pc_src,
   output logic                reg_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                halted,
   output logic                bus_err,
   output logic                illegal,
   output logic [3:0]          state,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    instr_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_WB_R     = 4'd3,
      S_EXEC_I   = 4'd4,
      S_WB_I     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12,
      S_ERR      = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_BGTZ  = 6'd7;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_SLTIU = 6'd11;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SH    = 6'd41;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [5:0] F_SLL     = 6'd0;
   localparam logic [5:0] F_SRL     = 6'd2;
   localparam logic [5:0] F_SRA     = 6'd3;
   localparam logic [5:0] F_SLLV    = 6'd4;
   localparam logic [5:0] F_JR      = 6'd8;
   localparam logic [5:0] F_SYSCALL = 6'd12;
   localparam logic [5:0] F_ADD     = 6'd32;
   localparam logic [5:0] F_ADDU    = 6'd33;
   localparam logic [5:0] F_SUB     = 6'd34;
   localparam logic [5:0] F_SUBU    = 6'd35;
   localparam logic [5:0] F_AND     = 6'd36;
   localparam logic [5:0] F_OR      = 6'd37;
   localparam logic [5:0] F_NOR     = 6'd39;
   localparam logic [5:0] F_SLT     = 6'd42;
   localparam logic [5:0] F_SLTU    = 6'd43;

   localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(7);
   localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(10);
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(11);
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(12);
   localparam logic [ALU_OP_W-1:0] ALU_DEF  = ALU_OP_W'(13);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;

   logic [ALU_OP_W-1:0] r_alu, i_alu;
   logic                r_ok, i_sext, is_jr, is_sys;
   logic [1:0]          br_code;
   state_e              dec_next;
   logic                dec_ill;
   logic                timeout;
   logic                ins_inc;

   // R-type function field decode
   always_comb begin
      r_alu = ALU_DEF;
      r_ok  = 1'b1;
      case (func)
         F_SLL:   r_alu = ALU_SLL;
         F_SLLV:  r_alu = ALU_SLL;
         F_SRA:   r_alu = ALU_SRA;
         F_SRL:   r_alu = ALU_SRL;
         F_ADD:   r_alu = ALU_ADD;
         F_ADDU:  r_alu = ALU_ADD;
         F_SUB:   r_alu = ALU_SUB;
         F_SUBU:  r_alu = ALU_SUB;
         F_AND:   r_alu = ALU_AND;
         F_OR:    r_alu = ALU_OR;
         F_NOR:   r_alu = ALU_NOR;
         F_SLT:   r_alu = ALU_SLT;
         F_SLTU:  r_alu = ALU_SLTU;
         default: r_ok  = 1'b0;
      endcase
   end

   // I-type ALU op and extension mode
   always_comb begin
      i_alu  = ALU_DEF;
      i_sext = 1'b0;
      case (op)
         OP_ADDI:  begin i_alu = ALU_ADD;  i_sext = 1'b1; end
         OP_ADDIU: begin i_alu = ALU_ADD;  i_sext = 1'b1; end
         OP_SLTI:  begin i_alu = ALU_SLT;  i_sext = 1'b1; end
         OP_SLTIU: i_alu = ALU_SLTU;
         OP_ANDI:  i_alu = ALU_AND;
         OP_ORI:   i_alu = ALU_OR;
         default:  i_alu = ALU_DEF;
      endcase
   end

   assign is_jr  = (op == OP_RTYPE) && (func == F_JR);
   assign is_sys = (op == OP_RTYPE) && (func == F_SYSCALL);

   always_comb begin
      br_code = 2'b00;
      case (op)
         OP_BEQ:  br_code = 2'b01;
         OP_BNE:  br_code = 2'b10;
         OP_BGTZ: br_code = 2'b11;
         default: br_code = 2'b00;
      endcase
   end

   // DECODE dispatch
   always_comb begin
      dec_next = S_FETCH;
      dec_ill  = 1'b0;
      unique case (1'b1)
         is_jr:                dec_next = S_JUMP;
         is_sys:               dec_next = S_HALT;
         (op == OP_RTYPE) && r_ok:
                               dec_next = S_EXEC_R;
         (op == OP_ADDI)  ||
         (op == OP_ADDIU) ||
         (op == OP_SLTI)  ||
         (op == OP_SLTIU) ||
         (op == OP_ANDI)  ||
         (op == OP_ORI):       dec_next = S_EXEC_I;
         (op == OP_LW) ||
         (op == OP_SW) ||
         (op == OP_SH):        dec_next = S_MEM_ADDR;
         (op == OP_BEQ) ||
         (op == OP_BNE) ||
         (op == OP_BGTZ):      dec_next = S_BRANCH;
         (op == OP_J) ||
         (op == OP_JAL):       dec_next = S_JUMP;
         default:              dec_ill  = 1'b1;
      endcase
   end

   // last permitted wait cycle: a miss here means bus error
   assign timeout = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      wait_d     = '0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_mode   = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      signed_ext = 1'b0;
      alu_op     = '0;
      shift_var  = 1'b0;
      branch     = 2'b00;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      halted     = 1'b0;
      bus_err    = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            alu_src_b  = 2'd3;
            alu_op     = ALU_ADD;
            signed_ext = 1'b1;
            illegal    = dec_ill;
            state_d    = dec_next;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = r_alu;
            shift_var = (func == F_SLLV);
            state_d   = S_WB_R;
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 2'd1;
            state_d   = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            signed_ext = i_sext;
            alu_op     = i_alu;
            state_d    = S_WB_I;
         end
         S_WB_I: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            signed_ext = 1'b1;
            alu_op     = ALU_ADD;
            state_d    = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               state_d = S_WB_MEM;
            end else if (timeout) begin
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'd1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            mem_mode  = (op == OP_SH) ? 2'b01 : 2'b10;
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (timeout) begin
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            branch    = br_code;
            pc_src    = 2'd1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = is_jr ? 2'd3 : 2'd2;
            if (op == OP_JAL) begin
               reg_write  = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
            end
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (resume) state_d = S_FETCH;
         end
         S_ERR: begin
            bus_err = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // SYSCALL retires on entry to HALT, so leaving HALT is not counted
   always_comb begin
      ins_inc = 1'b0;
      if (state_q == S_DECODE)
         ins_inc = (state_d == S_HALT);
      else if (state_d == S_FETCH &&
               state_q != S_FETCH &&
               state_q != S_HALT)
         ins_inc = 1'b1;
   end

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if (state_q != S_HALT && state_q != S_ERR)
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      instr_cnt_d = instr_cnt_q + CNT_W'(ins_inc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         wait_q      <= '0;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign state     = state_q;
   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction
// sequences queue expected per-cycle values; a monitor compares.
module tb_multicycle_ctrl;

   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic [5:0]    op, func;
   logic          mem_ready, resume;
   logic          ir_write, pc_write, iord;
   logic          mem_read, mem_write;
   logic [1:0]    mem_mode;
   logic          alu_src_a;
   logic [1:0]    alu_src_b;
   logic          signed_ext;
   logic [3:0]    alu_op;
   logic          shift_var;
   logic [1:0]    branch, pc_src;
   logic          reg_write;
   logic [1:0]    reg_dst, mem_to_reg;
   logic          halted, bus_err, illegal;
   logic [3:0]    state;
   logic [CW-1:0] cycle_cnt, instr_cnt;

   multicycle_ctrl #(
      .ALU_OP_W(4), .CNT_W(CW), .MEM_TIMEOUT(15)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func(func),
      .mem_ready(mem_ready), .resume(resume),
      .ir_write(ir_write), .pc_write(pc_write), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_mode(mem_mode), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .signed_ext(signed_ext),
      .alu_op(alu_op), .shift_var(shift_var),
      .branch(branch), .pc_src(pc_src),
      .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .halted(halted),
      .bus_err(bus_err), .illegal(illegal), .state(state),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int ST = 0, MRD = 1, MWR = 2, IORD = 3, MODE = 4;
   localparam int ALU = 5, BR = 6, PCS = 7, RW = 8, RDST = 9;
   localparam int M2R = 10, HLT = 11, BERR = 12, ILL = 13;
   localparam int CYC = 14, INS = 15, IRW = 16, PCW = 17;
   localparam int SEXT = 18;

   typedef struct {
      int          due;
      int          sig;
      logic [31:0] v;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [31:0] sig_val(int id);
      case (id)
         ST:   return 32'(state);
         MRD:  return 32'(mem_read);
         MWR:  return 32'(mem_write);
         IORD: return 32'(iord);
         MODE: return 32'(mem_mode);
         ALU:  return 32'(alu_op);
         BR:   return 32'(branch);
         PCS:  return 32'(pc_src);
         RW:   return 32'(reg_write);
         RDST: return 32'(reg_dst);
         M2R:  return 32'(mem_to_reg);
         HLT:  return 32'(halted);
         BERR: return 32'(bus_err);
         ILL:  return 32'(illegal);
         CYC:  return 32'(cycle_cnt);
         INS:  return 32'(instr_cnt);
         IRW:  return 32'(ir_write);
         PCW:  return 32'(pc_write);
         SEXT: return 32'(signed_ext);
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic push(int dly, int sig, logic [31:0] v,
                       string nm);
      exp_t e;
      e.due = cyc + dly;
      e.sig = sig;
      e.v   = v;
      e.nm  = nm;
      q.push_back(e);
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // monitor: compare every queued expectation due this cycle
   initial begin
      forever begin
         @(negedge clk);
         begin
            int i;
            i = 0;
            while (i < q.size()) begin
               if (q[i].due == cyc) begin
                  logic [31:0] got;
                  got = sig_val(q[i].sig);
                  n_tests++;
                  if (got !== q[i].v) begin
                     n_fail++;
                     $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                              q[i].nm, got, q[i].v, cyc);
                  end
                  q.delete(i);
               end else if (q[i].due < cyc) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL %s: missed check, due %0d",
                           q[i].nm, q[i].due);
                  q.delete(i);
               end else begin
                  i++;
               end
            end
         end
      end
   end

   // reset is asserted one cycle after the call; outputs are
   // checked while rst_n is low, then it is released
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      resume    = 1'b0;
      op        = 6'd0;
      func      = 6'd0;
      push(0, ST,   0, "rst_state");
      push(0, MWR,  0, "rst_mem_write");
      push(0, MRD,  1, "rst_fetch_read");
      push(0, CYC,  0, "rst_cycle_cnt");
      push(0, INS,  0, "rst_instr_cnt");
      push(0, BERR, 0, "rst_bus_err");
      push(0, HLT,  0, "rst_halted");
      tick(1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      op        = 6'd0;
      func      = 6'd0;
      mem_ready = 1'b0;
      resume    = 1'b0;

      // ADD
      do_reset();
      op = 6'd0; func = 6'd32; mem_ready = 1'b1;
      push(0, ST, 0, "add_fetch");
      push(0, MRD, 1, "add_fetch_read");
      push(0, IRW, 1, "add_ir_write");
      push(1, ST, 1, "add_decode");
      push(2, ST, 2, "add_exec");
      push(2, ALU, 5, "add_alu_op");
      push(3, ST, 3, "add_wb");
      push(3, RW, 1, "add_reg_write");
      push(3, RDST, 1, "add_reg_dst");
      push(4, ST, 0, "add_back_fetch");
      push(4, INS, 1, "add_instr_cnt");
      push(4, CYC, 4, "add_cycle_cnt");
      tick(4);

      // LW with 3 wait cycles in MEM_RD
      do_reset();
      op = 6'd35; func = 6'd0; mem_ready = 1'b1;
      push(1, ST, 1, "lw_decode");
      push(2, ST, 6, "lw_mem_addr");
      for (int d = 3; d <= 6; d++) begin
         push(d, ST, 7, "lw_mem_rd");
         push(d, MRD, 1, "lw_mem_read");
         push(d, IORD, 1, "lw_iord");
      end
      push(7, ST, 8, "lw_wb_mem");
      push(7, M2R, 1, "lw_mem_to_reg");
      push(7, RW, 1, "lw_reg_write");
      push(8, ST, 0, "lw_back_fetch");
      push(8, CYC, 8, "lw_cycle_cnt");
      push(8, INS, 1, "lw_instr_cnt");
      tick(3);
      mem_ready = 1'b0;
      tick(3);
      mem_ready = 1'b1;
      tick(5);

      // SH
      do_reset();
      op = 6'd41; func = 6'd0; mem_ready = 1'b1;
      for (int d = 0; d <= 4; d++) push(d, RW, 0, "sh_no_reg_write");
      push(3, ST, 9, "sh_mem_wr");
      push(3, MWR, 1, "sh_mem_write");
      push(3, MODE, 1, "sh_mem_mode");
      push(4, ST, 0, "sh_back_fetch");
      push(4, INS, 1, "sh_instr_cnt");
      tick(4);

      // SW, then reset while the write is stalled
      do_reset();
      op = 6'd43; func = 6'd0; mem_ready = 1'b1;
      for (int d = 0; d <= 4; d++) push(d, RW, 0, "sw_no_reg_write");
      push(3, ST, 9, "sw_mem_wr");
      push(3, MODE, 2, "sw_mem_mode");
      push(3, MWR, 1, "sw_mem_write");
      push(4, ST, 9, "sw_stalled");
      push(4, MWR, 1, "sw_write_held");
      tick(3);
      mem_ready = 1'b0;
      tick(1);

      // FETCH timeout to ERR
      do_reset();
      op = 6'd0; func = 6'd32; mem_ready = 1'b0;
      push(0, ST, 0, "to_fetch");
      push(5, IRW, 0, "to_no_ir_write");
      push(5, MRD, 1, "to_read_held");
      push(14, ST, 0, "to_last_wait");
      push(15, ST, 13, "to_err");
      push(15, BERR, 1, "to_bus_err");
      push(15, CYC, 15, "to_cycle_cnt");
      push(20, ST, 13, "to_err_sticky");
      push(20, CYC, 15, "to_cycle_frozen");
      push(20, MRD, 0, "to_no_read_err");
      tick(17);
      resume = 1'b1;
      tick(1);
      resume = 1'b0;
      tick(2);

      // ready arriving on the last allowed wait cycle
      do_reset();
      op = 6'd0; func = 6'd32; mem_ready = 1'b0;
      push(14, ST, 0, "lim_fetch");
      push(14, IRW, 1, "lim_ir_write");
      push(15, ST, 1, "lim_decode");
      push(16, ST, 2, "lim_exec");
      tick(14);
      mem_ready = 1'b1;
      tick(3);

      // SYSCALL halt and resume
      do_reset();
      op = 6'd0; func = 6'd12; mem_ready = 1'b1;
      push(1, ST, 1, "sys_decode");
      push(2, ST, 12, "sys_halt");
      push(2, HLT, 1, "sys_halted");
      push(2, INS, 1, "sys_instr_cnt");
      push(2, CYC, 2, "sys_cycle_cnt");
      push(12, ST, 12, "sys_still_halt");
      push(12, CYC, 2, "sys_cycle_frozen");
      push(13, ST, 0, "sys_resumed");
      push(13, HLT, 0, "sys_not_halted");
      push(13, CYC, 2, "sys_cycle_after");
      push(13, INS, 1, "sys_no_recount");
      push(14, CYC, 3, "sys_cycle_runs");
      tick(12);
      resume = 1'b1;
      tick(1);
      resume = 1'b0;
      tick(2);

      // illegal opcode
      do_reset();
      op = 6'd63; func = 6'd0; mem_ready = 1'b1;
      push(0, ILL, 0, "ill_quiet_fetch");
      push(1, ST, 1, "ill_decode");
      push(1, ILL, 1, "ill_pulse");
      push(2, ST, 0, "ill_back_fetch");
      push(2, ILL, 0, "ill_pulse_end");
      push(2, INS, 0, "ill_instr_cnt");
      push(2, CYC, 2, "ill_cycle_cnt");
      tick(2);

      // JAL
      do_reset();
      op = 6'd3; func = 6'd0; mem_ready = 1'b1;
      push(2, ST, 11, "jal_jump");
      push(2, PCS, 2, "jal_pc_src");
      push(2, RDST, 2, "jal_reg_dst");
      push(2, M2R, 2, "jal_mem_to_reg");
      push(2, RW, 1, "jal_reg_write");
      push(2, PCW, 1, "jal_pc_write");
      push(3, ST, 0, "jal_back_fetch");
      push(3, INS, 1, "jal_instr_cnt");
      tick(3);

      // BNE
      do_reset();
      op = 6'd5; func = 6'd0; mem_ready = 1'b1;
      push(2, ST, 10, "bne_branch");
      push(2, BR, 2, "bne_branch_code");
      push(2, ALU, 6, "bne_alu_op");
      push(2, PCS, 1, "bne_pc_src");
      push(2, PCW, 0, "bne_no_pc_write");
      push(3, ST, 0, "bne_back_fetch");
      push(3, INS, 1, "bne_instr_cnt");
      tick(3);

      // ANDI
      do_reset();
      op = 6'd12; func = 6'd0; mem_ready = 1'b1;
      push(2, ST, 4, "andi_exec");
      push(2, ALU, 7, "andi_alu_op");
      push(2, SEXT, 0, "andi_zero_ext");
      push(3, ST, 5, "andi_wb");
      push(3, RW, 1, "andi_reg_write");
      push(3, RDST, 0, "andi_reg_dst");
      tick(4);

      // 16 back-to-back ADDs: 4-bit counters wrap
      do_reset();
      op = 6'd0; func = 6'd32; mem_ready = 1'b1;
      push(16, CYC, 0, "wrap_cycle_16");
      push(16, INS, 4, "wrap_instr_4");
      push(60, CYC, 12, "wrap_cycle_60");
      push(60, INS, 15, "wrap_instr_15");
      push(64, ST, 0, "wrap_fetch");
      push(64, CYC, 0, "wrap_cycle_64");
      push(64, INS, 0, "wrap_instr_0");
      tick(64);

      for (int i = 0; i < 200 && q.size() > 0; i++) tick(1);
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d pending, required 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle MIPS control decoder. Same instruction set, same ALU_OP encoding.
- A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. Stalls on a memory ready handshake, times out on a missing ready, halts on SYSCALL.
- Sits between the instruction register and the shared-memory multicycle datapath. Also exposes retired-instruction and cycle counters for the debug display.

Parameters:
- ALU_OP_W, 4, width of alu_op.
- CNT_W, 32, width of cycle_cnt and instr_cnt.
- MEM_TIMEOUT, 15, maximum cycles a memory state waits for mem_ready before bus error; must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]; valid from DECODE onward
- func  in  6  IR[5:0]
- mem_ready  in  1  memory completes current read/write this cycle
- resume  in  1  single-cycle pulse, leaves HALT
- ir_write, pc_write  out  1  register enables
- iord  out  1  0: PC addresses memory, 1: ALUOut
- mem_read, mem_write  out  1  memory strobes, held until mem_ready
- mem_mode  out  2  01 halfword (SH), 10 word
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  0 rt, 1 const 4, 2 ext imm, 3 sext imm<<2
- signed_ext  out  1  sign (1) / zero (0) extend imm
- alu_op  out  ALU_OP_W  5 add, 0 sll/sllv, 1 sra, 2 srl, 6 sub, 7 and, 8 or, 10 nor, 11 slt, 12 sltu, 13 default
- shift_var  out  1  SLLV: shift amount from rs
- branch  out  2  00 none, 01 beq, 10 bne, 11 bgtz
- pc_src  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 rs
- reg_write  out  1  register file write enable
- reg_dst  out  2  0 rt, 1 rd, 2 r31
- mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC
- halted, bus_err, illegal  out  1  status
- state  out  4  current state encoding
- cycle_cnt, instr_cnt  out  CNT_W  counters

Behaviour:
- Reset, asynchronous on rst_n low: state=FETCH, wait counter 0, both counters 0, halted/bus_err/illegal 0.
- Outputs are a combinational decode of state, op and func. Any output not driven by the current state is 0. All outputs reach these values immediately on reset.
- FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=5. On mem_ready: ir_write=1, pc_write=1, pc_src=0, next DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=3, alu_op=5, signed_ext=1 (branch target into ALUOut). Next state by op/func:
  - R-type → EXEC_R; JR → JUMP; SYSCALL → HALT.
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI → EXEC_I.
  - LW/SW/SH → MEM_ADDR.
  - BEQ/BNE/BGTZ → BRANCH; J/JAL → JUMP.
  - Any other op/func: illegal pulses 1 for one cycle, next FETCH; instr_cnt does not increment.
- EXEC_R (2): alu_src_a=1, alu_src_b=0, alu_op per func, shift_var=SLLV. Next WB_R.
- WB_R (3): reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- EXEC_I (4): alu_src_a=1, alu_src_b=2, signed_ext=1 for ADDI/ADDIU/SLTI, 0 for SLTIU/ANDI/ORI; alu_op per op. Next WB_I.
- WB_I (5): reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- MEM_ADDR (6): alu_src_a=1, alu_src_b=2, signed_ext=1, alu_op=5. Next MEM_RD for LW, MEM_WR for SW/SH.
- MEM_RD (7): mem_read=1, iord=1. On mem_ready → WB_MEM.
- WB_MEM (8): reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WR (9): mem_write=1, iord=1, mem_mode=01 for SH else 10. On mem_ready → FETCH.
- BRANCH (10): alu_src_a=1, alu_src_b=0, alu_op=6, branch per op, pc_src=1; datapath gates the PC write. Next FETCH.
- JUMP (11): pc_write=1, pc_src=3 for JR else 2. For JAL also reg_write=1, reg_dst=2, mem_to_reg=2. Next FETCH.
- HALT (12): halted=1; stays until resume=1, then FETCH. resume outside HALT is ignored.
- ERR (13): bus_err=1; leaves only via reset.
- Memory wait: counter clears on entering FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0. When it reaches MEM_TIMEOUT with mem_ready still 0, next ERR. mem_ready=1 on the same cycle as reaching the limit wins.
- Strobes are held constant across wait cycles; ir_write/pc_write assert only on the mem_ready cycle.
- cycle_cnt: +1 every cycle except in HALT and ERR.
- instr_cnt: +1 on the cycle leaving any state whose next state is FETCH, excluding the illegal path; SYSCALL counts on entry to HALT.
- Both counters wrap modulo 2^CNT_W.
- rst_n asserted mid-instruction aborts immediately; no partial write strobe persists after reset.

Test Plan:
- Reset then FETCH with mem_ready=1, op=0, func=32 (ADD): states 0,1,2,3,0; alu_op=5 in EXEC_R; reg_write=1 with reg_dst=1 in WB_R; instr_cnt=1 and cycle_cnt=4 when state returns to 0.
- LW (op=35) with mem_ready held low 3 cycles in MEM_RD: mem_read/iord stay 1 for 4 cycles; WB_MEM gives mem_to_reg=1; 8 cycles total with a zero-wait fetch.
- SH (op=41): MEM_WR has mem_write=1, mem_mode=01. SW (op=43): mem_mode=10. Neither asserts reg_write in any state.
- mem_ready stuck 0 in FETCH with MEM_TIMEOUT=15: ERR entered after 15 wait cycles, bus_err=1; only rst_n low returns state=0 with counters 0.
- SYSCALL (op=0, func=12): HALT, halted=1, cycle_cnt frozen over 10 idle cycles; resume pulse → FETCH. op=63: illegal one-cycle pulse, instr_cnt unchanged.
- JAL (op=3): JUMP has pc_src=2, reg_dst=2, mem_to_reg=2, reg_write=1. BNE (op=5): branch=10, alu_op=6. CNT_W=4: counters wrap 15→0.
